dac8812_sequencer: RTL and testbench
====================================

DAC8812_SEQUENCER -- requirements
Module: dac8812_sequencer

Interface
REQ-001 SHALL have parameter PERIOD, 1000, update period in clk cycles (>=2).
REQ-002 SHALL have parameter GUARD, 4, idle clk cycles inserted after the serializer drops busy and before the next start (>=1).
REQ-003 SHALL have parameter DEPTH, 4, sample-pair FIFO depth (power of 2, >=2).
REQ-004 SHALL have parameter SIGNED_IN, 1, 1 = two's-complement inputs converted to offset binary; 0 = pass-through.
REQ-005 Ports, in order: clk  input  1  clock (rising edge); rst  input  1  reset, synchronous, active-high.
REQ-006 s_valid  input  1  upstream sample pair valid; s_ready  output  1  FIFO not full.
REQ-007 s_data_a  input  16  channel A code; s_data_b  input  16  channel B code.
REQ-008 en  input  1  enables the update timer; clr_flags  input  1  clears the sticky flags and the underrun count.
REQ-009 dac_start  output  1  single-cycle start pulse to the serializer; dac_data  output  18  word {addr[1:0], code[15:0]}.
REQ-010 dac_busy  input  1  serializer busy.
REQ-011 underrun  output  1  sticky; overrun  output  1  sticky; underrun_cnt  output  16  saturating count; level  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-012 FIFO: a push occurs when s_valid & s_ready; s_ready = (level < DEPTH); a pop occurs only in IDLE on a tick; a simultaneous push and pop leaves level unchanged.
REQ-013 Pointers SHALL wrap modulo DEPTH; a push while full and a pop while empty SHALL never occur.
REQ-014 Timer: counts 0..PERIOD-1 while en=1 and emits tick when count = PERIOD-1; en=0 holds the count and suppresses ticks.
REQ-015 FSM states: IDLE, START_A, WAIT_A, GAP_A, START_B, WAIT_B, GAP_B.
REQ-016 IDLE, tick, level>0 -> pop the pair into holding registers A/B, go to START_A.
REQ-017 IDLE, tick, level=0 -> set underrun, increment underrun_cnt (saturating at 16'hFFFF), stay in IDLE; the DAC holds its last value.
REQ-018 START_A: dac_start=1 for exactly one cycle, dac_data={2'b01, A}; next state WAIT_A.
REQ-019 WAIT_A: first wait for dac_busy=1, then for dac_busy=0, then go to GAP_A; dac_data SHALL be held stable throughout.
REQ-020 GAP_A: count GUARD cycles (this covers the serializer's LDAC pulse), then go to START_B.
REQ-021 START_B/WAIT_B/GAP_B: identical to the A states with dac_data={2'b10, B}; GAP_B exits to IDLE.
REQ-022 A tick in any state other than IDLE SHALL set overrun and is otherwise ignored; no pop occurs.
REQ-023 Conversion: when SIGNED_IN=1, code = {~x[15], x[14:0]} (16'h8000 -> 16'h0000, 16'h7FFF -> 16'hFFFF); conversion SHALL be applied at pop time.
REQ-024 clr_flags SHALL clear underrun, overrun and underrun_cnt; an event in the same cycle as clr_flags wins (flag=1, cnt=1).
REQ-025 Latency: dac_start SHALL assert on the cycle after the popping tick.
REQ-026 Outputs SHALL be registered, except s_ready and level, which are decoded from the registered occupancy.

Reset
REQ-027 rst SHALL force: FSM=IDLE, FIFO empty (level=0, s_ready=1), timer=0, dac_start=0, dac_data=0, underrun=0, overrun=0, underrun_cnt=0.
REQ-028 rst mid-transfer SHALL abort the sequence and discard FIFO contents; no further dac_start occurs until a new tick with level>0.
REQ-029 rst SHALL take priority over all other inputs.

Verification
REQ-030 Push (16'h0000, 16'h7FFF) with SIGNED_IN=1 and a serializer model (busy for 40 cycles) -> dac_data 18'h18000 then 18'h2FFFF, one dac_start each, gap >= GUARD cycles after busy falls.
REQ-031 en=1 with the FIFO empty for 3 ticks -> underrun=1, underrun_cnt=3, no dac_start; clr_flags -> all cleared.
REQ-032 PERIOD=50 with busy held 40 cycles per word -> overrun=1 on the next tick, and the A/B order is still preserved.
REQ-033 Push DEPTH+1 pairs with en=0 -> s_ready=0 after DEPTH pairs and level=DEPTH; the extra pair is not accepted.
REQ-034 rst asserted during WAIT_B -> the next cycle shows the IDLE outputs and level=0; dac_start is silent until a new push and tick.
REQ-035 Simultaneous push and pop at level=1 -> level remains 1, and data order is preserved across pointer wrap over 2*DEPTH pairs.

Source files
------------

// File: rtl/dac8812_sequencer.sv
// Update-rate sequencer for a dual-channel DAC8812: buffers A/B sample pairs,
// then on each timer tick sends channel A and then channel B to the serializer.
module dac8812_sequencer #(
  parameter int PERIOD    = 1000,
  parameter int GUARD     = 4,
  parameter int DEPTH     = 4,
  parameter int SIGNED_IN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [15:0]              s_data_a,
  input  logic [15:0]              s_data_b,
  input  logic                     en,
  input  logic                     clr_flags,
  output logic                     dac_start,
  output logic [17:0]              dac_data,
  input  logic                     dac_busy,
  output logic                     underrun,
  output logic                     overrun,
  output logic [15:0]              underrun_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(PERIOD);
  localparam int GW = $clog2(GUARD + 1);
  localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] T_LAST = TW'(PERIOD - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GUARD - 1);

  typedef enum logic [2:0] {
    IDLE, START_A, WAIT_A, GAP_A, START_B, WAIT_B, GAP_B
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            tick;
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            push, pop;
  logic [1:0][15:0] rd_code;
  logic            seen_busy_q;
  logic [GW-1:0]   gcnt_q;
  logic [15:0]     hold_b_q;
  logic            dac_start_q;
  logic [17:0]     dac_data_q;
  logic            underrun_q, overrun_q;
  logic [15:0]     underrun_cnt_q;
  logic            underrun_evt, overrun_evt;

  // Update timer: wraps at PERIOD-1, frozen while disabled.
  assign tick = en && (tmr_q == T_LAST);

  always_comb begin
    tmr_d = tmr_q;
    if (en) begin
      tmr_d = (tmr_q == T_LAST) ? '0 : tmr_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign s_ready = (count_q < FULL);
  assign level   = count_q;
  assign push    = s_valid && s_ready;
  assign pop     = (state_q == IDLE) && tick && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_data_a, s_data_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // Lane 1 carries channel A, lane 0 channel B; code conversion happens on the way out.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [15:0] raw;
    assign raw = mem_q[rd_ptr_q][16*gi +: 16];
    if (SIGNED_IN != 0) begin : g_offset
      assign rd_code[gi] = {~raw[15], raw[14:0]};
    end else begin : g_pass
      assign rd_code[gi] = raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dac_start_q <= 1'b0;
      dac_data_q  <= '0;
      seen_busy_q <= 1'b0;
      gcnt_q      <= '0;
      hold_b_q    <= '0;
    end else begin
      dac_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            hold_b_q    <= rd_code[0];
            dac_data_q  <= {2'b01, rd_code[1]};
            dac_start_q <= 1'b1;
            state_q     <= START_A;
          end
        end
        START_A, START_B: begin
          seen_busy_q <= 1'b0;
          gcnt_q      <= '0;
          state_q     <= (state_q == START_A) ? WAIT_A : WAIT_B;
        end
        // Busy must be seen high before its falling edge ends the word.
        WAIT_A, WAIT_B: begin
          if (!seen_busy_q) begin
            if (dac_busy) begin
              seen_busy_q <= 1'b1;
            end
          end else if (!dac_busy) begin
            state_q <= (state_q == WAIT_A) ? GAP_A : GAP_B;
          end
        end
        GAP_A: begin
          if (gcnt_q == G_LAST) begin
            dac_data_q  <= {2'b10, hold_b_q};
            dac_start_q <= 1'b1;
            state_q     <= START_B;
          end else begin
            gcnt_q <= gcnt_q + GW'(1);
          end
        end
        GAP_B: begin
          if (gcnt_q == G_LAST) begin
            state_q <= IDLE;
          end else begin
            gcnt_q <= gcnt_q + GW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign underrun_evt = (state_q == IDLE) && tick && (count_q == '0);
  assign overrun_evt  = tick && (state_q != IDLE);

  // A new event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_q     <= 1'b0;
      overrun_q      <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      if (underrun_evt) begin
        underrun_q <= 1'b1;
        if (clr_flags) begin
          underrun_cnt_q <= 16'd1;
        end else if (underrun_cnt_q != 16'hFFFF) begin
          underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
      end else if (clr_flags) begin
        underrun_q     <= 1'b0;
        underrun_cnt_q <= '0;
      end
      if (overrun_evt) begin
        overrun_q <= 1'b1;
      end else if (clr_flags) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign dac_start    = dac_start_q;
  assign dac_data     = dac_data_q;
  assign underrun     = underrun_q;
  assign overrun      = overrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_dac8812_sequencer.sv
// Bench for dac8812_sequencer: fill table, timing/flag sequences, reset abort,
// and randomized data streamed through a pointer wrap against a pair-level model.
module tb_dac8812_sequencer;

  localparam int PERIOD  = 50;
  localparam int GUARD   = 4;
  localparam int DEPTH   = 4;
  localparam int SER_DLY = 2;
  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int NWRAP   = 2 * DEPTH + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          en = 1'b0;
  logic          clr_flags = 1'b0;
  logic          dac_busy = 1'b0;
  logic [15:0]   s_data_a = '0;
  logic [15:0]   s_data_b = '0;
  logic          s_ready, dac_start, underrun, overrun;
  logic [17:0]   dac_data;
  logic [15:0]   underrun_cnt;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  dac8812_sequencer #(
    .PERIOD(PERIOD), .GUARD(GUARD), .DEPTH(DEPTH), .SIGNED_IN(1)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data_a(s_data_a), .s_data_b(s_data_b),
    .en(en), .clr_flags(clr_flags),
    .dac_start(dac_start), .dac_data(dac_data),
    .dac_busy(dac_busy),
    .underrun(underrun), .overrun(overrun),
    .underrun_cnt(underrun_cnt), .level(level)
  );

  typedef struct {
    logic [17:0] data;
    int          gap;
  } start_t;

  start_t      got_q[$];
  int          cyc = 0;
  int          last_fall = -1;
  int          stab_bad = 0;
  int          ser_cnt = 0;
  int          busy_len = 8;
  logic        busy_prev = 1'b0;
  logic [17:0] last_word = '0;

  // Serializer model and start recorder: busy rises SER_DLY cycles after a
  // start and stays high for busy_len cycles.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      got_q.delete();
      last_fall = -1;
      stab_bad  = 0;
      ser_cnt   = 0;
      dac_busy  = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (dac_busy && dac_data !== last_word) stab_bad++;
      if (dac_start) begin
        got_q.push_back('{dac_data, (last_fall < 0) ? -1 : cyc - last_fall - 1});
        last_word = dac_data;
        ser_cnt   = SER_DLY + busy_len;
      end else if (ser_cnt > 0) begin
        ser_cnt--;
      end
      dac_busy = (ser_cnt > 0) && (ser_cnt <= busy_len);
      if (busy_prev && !dac_busy) last_fall = cyc;
      busy_prev = dac_busy;
    end
  end

  int errors = 0;
  int checks = 0;
  logic [17:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; en = 1'b0; clr_flags = 1'b0;
    step(2);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Offset binary is the two's-complement value shifted up by half scale.
  function automatic logic [15:0] to_code(input logic [15:0] x);
    return x + 16'h8000;
  endfunction

  task automatic expect_pair(input logic [15:0] a, input logic [15:0] b);
    exp_q.push_back({2'b01, to_code(a)});
    exp_q.push_back({2'b10, to_code(b)});
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    s_valid = 1'b1; s_data_a = a; s_data_b = b;
    step(1);
    s_valid = 1'b0;
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check({tag, "_start_timeout"}, 32'(got_q.size() >= n), 1);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_words"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_word%0d", tag, i), 32'(got_q[i].data), 32'(exp_q[i]));
      if (got_q[i].gap >= 0)
        check($sformatf("%s_gap%0d", tag, i), 32'(got_q[i].gap >= GUARD), 1);
    end
    check({tag, "_stable"}, stab_bad, 0);
  endtask

  typedef struct {
    logic        valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        exp_ready;
    logic [2:0]  exp_level;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    int          model_n;
    int          k;
    logic [15:0] ra, rb;

    vecs[0] = '{1'b1, 16'($urandom), 16'($urandom), 1'b1, 3'd1};
    vecs[1] = '{1'b1, 16'($urandom), 16'($urandom), 1'b1, 3'd2};
    vecs[2] = '{1'b1, 16'($urandom), 16'($urandom), 1'b1, 3'd3};
    vecs[3] = '{1'b1, 16'($urandom), 16'($urandom), 1'b0, 3'd4};
    vecs[4] = '{1'b1, 16'($urandom), 16'($urandom), 1'b0, 3'd4};
    vecs[5] = '{1'b0, 16'h0000,      16'h0000,      1'b0, 3'd4};

    // Reset state
    do_reset();
    check("rst_ready", s_ready, 1);
    check("rst_level", level, 0);
    check("rst_start", dac_start, 0);
    check("rst_data", dac_data, 0);
    check("rst_underrun", underrun, 0);
    check("rst_overrun", overrun, 0);
    check("rst_ucnt", underrun_cnt, 0);

    // Fill past full with the timer stopped, then drain in order
    model_n = 0;
    for (int i = 0; i < 6; i++) begin
      s_valid = vecs[i].valid; s_data_a = vecs[i].a; s_data_b = vecs[i].b;
      if (vecs[i].valid && model_n < DEPTH) begin
        expect_pair(vecs[i].a, vecs[i].b);
        model_n++;
      end
      step(1);
      check($sformatf("fill%0d_ready", i), s_ready, vecs[i].exp_ready);
      check($sformatf("fill%0d_level", i), level, vecs[i].exp_level);
    end
    s_valid = 1'b0;
    check("fill_no_start", got_q.size(), 0);
    busy_len = 6;
    en = 1'b1;
    wait_starts("drain", 2 * DEPTH, 6 * PERIOD);
    en = 1'b0;
    step(40);
    check_stream("drain");
    check("drain_level", level, 0);
    check("drain_underrun", underrun, 0);
    check("drain_overrun", overrun, 0);

    // Extreme codes, tick-to-start latency, slow serializer forces an overrun
    do_reset();
    busy_len = 40;
    ra = 16'($urandom); rb = 16'($urandom);
    push(16'h0000, 16'h7FFF);
    push(ra, rb);
    exp_q.push_back(18'h18000);
    exp_q.push_back(18'h2FFFF);
    expect_pair(ra, rb);
    en = 1'b1;
    k = 0;
    while (!dac_start && k < 3 * PERIOD) begin
      step(1);
      k++;
    end
    check("first_start_edge", k, PERIOD);
    wait_starts("slow", 4, 5 * PERIOD);
    en = 1'b0;
    step(120);
    check_stream("slow");
    check("slow_overrun", overrun, 1);
    check("slow_underrun", underrun, 0);

    // Empty FIFO underruns, clear, then clear colliding with an underrun
    do_reset();
    en = 1'b1;
    step(3 * PERIOD + 5);
    check("ur_flag", underrun, 1);
    check("ur_cnt", underrun_cnt, 3);
    check("ur_no_start", got_q.size(), 0);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check("clr_underrun", underrun, 0);
    check("clr_ucnt", underrun_cnt, 0);
    check("clr_overrun", overrun, 0);
    step(PERIOD - 7);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check("clr_evt_flag", underrun, 1);
    check("clr_evt_cnt", underrun_cnt, 1);
    en = 1'b0;
    step(2 * PERIOD);
    check("en_off_hold_cnt", underrun_cnt, 1);

    // Reset during WAIT_B aborts the transfer and empties the FIFO
    do_reset();
    busy_len = 10;
    push(16'($urandom), 16'($urandom));
    push(16'($urandom), 16'($urandom));
    en = 1'b1;
    wait_starts("abort", 2, 3 * PERIOD);
    k = 0;
    while (!dac_busy && k < 20) begin
      step(1);
      k++;
    end
    check("abort_in_wait_b", dac_busy, 1);
    step(2);
    rst = 1'b1; s_valid = 1'b1; s_data_a = 16'($urandom); s_data_b = 16'($urandom);
    step(1);
    check("abort_start", dac_start, 0);
    check("abort_data", dac_data, 0);
    check("abort_level", level, 0);
    check("abort_ready", s_ready, 1);
    check("abort_overrun", overrun, 0);
    rst = 1'b0; s_valid = 1'b0;
    exp_q.delete();
    step(2 * PERIOD + 5);
    check("abort_silent", got_q.size(), 0);
    check("abort_ucnt", underrun_cnt, 2);
    ra = 16'($urandom); rb = 16'($urandom);
    push(ra, rb);
    expect_pair(ra, rb);
    wait_starts("post_rst", 2, 2 * PERIOD);
    en = 1'b0;
    step(40);
    check_stream("post_rst");

    // Push on every popping tick at level 1, through a pointer wrap
    do_reset();
    busy_len = $urandom_range(3, 10);
    ra = 16'($urandom); rb = 16'($urandom);
    push(ra, rb);
    expect_pair(ra, rb);
    check("wrap_preload", level, 1);
    en = 1'b1;
    for (int j = 1; j <= NWRAP; j++) begin
      step(PERIOD - 1);
      ra = 16'($urandom); rb = 16'($urandom);
      if (j < NWRAP) expect_pair(ra, rb);
      s_valid = 1'b1; s_data_a = ra; s_data_b = rb;
      step(1);
      s_valid = 1'b0;
      check($sformatf("wrap%0d_level", j), level, 1);
    end
    en = 1'b0;
    wait_starts("wrap", 2 * NWRAP, 2 * PERIOD);
    step(40);
    check_stream("wrap");
    check("wrap_end_level", level, 1);
    check("wrap_underrun", underrun, 0);
    check("wrap_overrun", overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
